// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, ready-handshake imem port,
// one-entry skid buffer for decode stalls, and the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_F,
   input  logic        flush_D,
   input  logic        PCSrc,
   input  logic [31:0] PCTarget,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PCPlus4_D,
   output logic        valid_D,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {IDLE, REQ, DROP, HELD} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] req_addr_reg;
   logic [31:0] skid_instr_reg, skid_pc_reg;
   logic [31:0] instr_d_reg, pc_d_reg, pcplus4_d_reg;
   logic        valid_d_reg;

   logic        deliver;
   logic        skid_load;
   logic [31:0] deliver_instr, deliver_pc;
   logic [31:0] target;

   assign target = {PCTarget[31:2], 2'b00};

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      deliver       = 1'b0;
      skid_load     = 1'b0;
      deliver_instr = imem_rdata;
      deliver_pc    = pc_reg;
      imem_req      = 1'b0;
      imem_addr     = pc_reg;
      fetch_busy    = 1'b0;
      case (state_reg)
         IDLE: begin
            state_next = REQ;
            if (PCSrc) pc_next = target;
         end
         REQ: begin
            // While in REQ the request address is the live PC; it only moves on completion or redirect
            imem_req   = 1'b1;
            imem_addr  = pc_reg;
            fetch_busy = !imem_ready;
            if (PCSrc) begin
               pc_next    = target;
               state_next = imem_ready ? REQ : DROP;
            end else if (imem_ready) begin
               pc_next = pc_reg + 32'd4;
               if (stall_F) begin
                  skid_load  = 1'b1;
                  state_next = HELD;
               end else begin
                  deliver = 1'b1;
               end
            end
         end
         DROP: begin
            // Old request must complete before the redirected address can be issued
            imem_req   = 1'b1;
            imem_addr  = req_addr_reg;
            fetch_busy = 1'b1;
            if (PCSrc) pc_next = target;
            if (imem_ready) state_next = REQ;
         end
         HELD: begin
            if (PCSrc) begin
               pc_next    = target;
               state_next = REQ;
            end else if (!stall_F) begin
               deliver       = 1'b1;
               deliver_instr = skid_instr_reg;
               deliver_pc    = skid_pc_reg;
               state_next    = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         pc_reg         <= RESET_PC;
         req_addr_reg   <= RESET_PC;
         skid_instr_reg <= NOP_INSTR;
         skid_pc_reg    <= 32'd0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         if (state_reg == REQ) req_addr_reg <= pc_reg;
         if (skid_load) begin
            skid_instr_reg <= imem_rdata;
            skid_pc_reg    <= pc_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_d_reg   <= NOP_INSTR;
         pc_d_reg      <= 32'd0;
         pcplus4_d_reg <= 32'd0;
         valid_d_reg   <= 1'b0;
      end else if (flush_D) begin
         instr_d_reg <= NOP_INSTR;
         valid_d_reg <= 1'b0;
      end else if (stall_F) begin
         instr_d_reg <= instr_d_reg;
      end else if (deliver) begin
         instr_d_reg   <= deliver_instr;
         pc_d_reg      <= deliver_pc;
         pcplus4_d_reg <= deliver_pc + 32'd4;
         valid_d_reg   <= 1'b1;
      end else begin
         instr_d_reg <= NOP_INSTR;
         valid_d_reg <= 1'b0;
      end
   end

   assign Instr_D   = instr_d_reg;
   assign PC_D      = pc_d_reg;
   assign PCPlus4_D = pcplus4_d_reg;
   assign valid_D   = valid_d_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a ROM model answers requests, a scoreboard queue holds
// the instructions decode should see, in order.
module tb_fetch_stage;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] BASE = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst, stall_F, flush_D, PCSrc, imem_ready;
   logic [31:0] PCTarget, imem_rdata, imem_addr;
   logic        imem_req, valid_D, fetch_busy;
   logic [31:0] Instr_D, PC_D, PCPlus4_D;

   logic        force_en;
   logic [31:0] force_data;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // ROM contents: each word is a fixed scramble of its own address
   assign imem_rdata = force_en ? force_data : (imem_addr ^ 32'h5A5A_5A5A);

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_F(stall_F), .flush_D(flush_D),
      .PCSrc(PCSrc), .PCTarget(PCTarget),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .valid_D(valid_D),
      .fetch_busy(fetch_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] rom(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   // One clock; a valid IF/ID value that was not merely held by a stall is a new delivery
   task automatic step();
      logic st;
      exp_t e;
      st = stall_F;
      @(posedge clk);
      #1;
      if (valid_D === 1'b1 && !st) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_instr got pc=%h instr=%h exp=none", PC_D, Instr_D);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("deliver pc=%h instr=%h (exp pc=%h instr=%h)", PC_D, Instr_D, e.pc, e.instr);
            chk("instr_d", Instr_D, e.instr);
            chk("pc_d", PC_D, e.pc);
            chk("pcplus4_d", PCPlus4_D, e.pc + 32'd4);
         end
      end
   endtask

   task automatic do_reset();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall_F = 1'b0; flush_D = 1'b0; PCSrc = 1'b0; PCTarget = 32'd0;
      imem_ready = 1'b1; force_en = 1'b0; force_data = 32'd0;

      // Reset values
      step();
      step();
      chk1("rst_req", imem_req, 1'b0);
      chk("rst_instr", Instr_D, NOP);
      chk("rst_pc", PC_D, 32'd0);
      chk("rst_pc4", PCPlus4_D, 32'd0);
      chk1("rst_valid", valid_D, 1'b0);
      chk1("rst_busy", fetch_busy, 1'b0);

      // Zero-wait sequential fetch
      rst = 1'b0;
      #1;
      chk1("idle_req", imem_req, 1'b0);
      for (int k = 0; k < 8; k++) push_exp(BASE + 32'(4 * k), rom(BASE + 32'(4 * k)));
      step();
      chk1("req_first", imem_req, 1'b1);
      chk("addr_first", imem_addr, BASE);
      for (int k = 0; k < 8; k++) begin
         step();
         chk1("seq_valid", valid_D, 1'b1);
         chk("seq_addr", imem_addr, BASE + 32'(4 * (k + 1)));
      end
      do_reset();

      // Wait states on the second fetch
      push_exp(BASE, rom(BASE));
      step();
      step();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("wait_busy", fetch_busy, 1'b1);
         chk("wait_addr", imem_addr, BASE + 32'd4);
         step();
         chk1("bubble_valid", valid_D, 1'b0);
         chk("bubble_instr", Instr_D, NOP);
      end
      imem_ready = 1'b1;
      #1;
      chk1("wait_done_busy", fetch_busy, 1'b0);
      push_exp(BASE + 32'd4, rom(BASE + 32'd4));
      push_exp(BASE + 32'd8, rom(BASE + 32'd8));
      step();
      step();

      // Stall with a completed fetch parked in the skid buffer
      stall_F = 1'b1; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
      #1;
      chk("skid_addr", imem_addr, BASE + 32'd12);
      step();
      force_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         chk1("held_req", imem_req, 1'b0);
         chk("held_pc_d", PC_D, BASE + 32'd8);
      end
      stall_F = 1'b0;
      push_exp(BASE + 32'd12, 32'hDEAD_BEEF);
      push_exp(BASE + 32'd16, rom(BASE + 32'd16));
      step();
      step();

      // Redirect while a request is waiting
      imem_ready = 1'b0;
      step();
      PCSrc = 1'b1; PCTarget = 32'hBFC0_0103;
      #1;
      chk1("pre_drop_busy", fetch_busy, 1'b1);
      step();
      PCSrc = 1'b0;
      #1;
      chk("drop_addr", imem_addr, BASE + 32'd20);
      chk1("drop_req", imem_req, 1'b1);
      chk1("drop_busy", fetch_busy, 1'b1);
      imem_ready = 1'b1; force_en = 1'b1; force_data = 32'hBAD0_BAD0;
      step();
      force_en = 1'b0;
      chk1("drop_valid", valid_D, 1'b0);
      chk("drop_instr", Instr_D, NOP);
      #1;
      chk("redirect_addr", imem_addr, 32'hBFC0_0100);
      push_exp(32'hBFC0_0100, rom(32'hBFC0_0100));
      push_exp(32'hBFC0_0104, rom(32'hBFC0_0104));
      step();
      step();

      // flush_D wins over stall_F
      flush_D = 1'b1; stall_F = 1'b1;
      step();
      chk("flush_instr", Instr_D, NOP);
      chk1("flush_valid", valid_D, 1'b0);
      chk("flush_pc_hold", PC_D, 32'hBFC0_0104);
      flush_D = 1'b0; stall_F = 1'b0;
      push_exp(32'hBFC0_0108, rom(32'hBFC0_0108));
      step();

      // Redirect to the top word; sequential fetch wraps to zero
      PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFF; flush_D = 1'b1;
      step();
      PCSrc = 1'b0; flush_D = 1'b0;
      chk1("wrap_bubble", valid_D, 1'b0);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC, rom(32'hFFFF_FFFC));
      push_exp(32'h0000_0000, rom(32'h0000_0000));
      step();
      chk("wrap_next_addr", imem_addr, 32'h0000_0000);
      step();

      // Reset while a request is outstanding
      imem_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk1("mid_rst_req", imem_req, 1'b0);
      chk("mid_rst_instr", Instr_D, NOP);
      chk("mid_rst_pc", PC_D, 32'd0);
      chk("mid_rst_pc4", PCPlus4_D, 32'd0);
      chk1("mid_rst_valid", valid_D, 1'b0);
      chk1("mid_rst_busy", fetch_busy, 1'b0);
      rst = 1'b0; imem_ready = 1'b1;
      step();
      chk1("post_rst_valid", valid_D, 1'b0);
      chk("post_rst_addr", imem_addr, BASE);
      push_exp(BASE, rom(BASE));
      step();

      chk("sb_final_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
